// File: rtl/qar_spi_arbiter.sv
// Round-robin arbiter that lends the shared SPI byte engine to one requester per
// transaction and drives its chip select with setup, hold and gap timing.
module qar_spi_arbiter #(
  parameter int NREQ     = 2,
  parameter int LENW     = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_cs,
  input  logic [LENW*NREQ-1:0] req_len,
  input  logic [8*NREQ-1:0]    req_tx_data,
  input  logic [NREQ-1:0]      req_tx_valid,
  output logic [NREQ-1:0]      req_tx_ready,
  output logic [NREQ-1:0]      gnt,
  output logic [7:0]           rx_data,
  output logic [NREQ-1:0]      rx_valid,
  output logic [NREQ-1:0]      done,
  output logic                 eng_start,
  output logic [7:0]           eng_tx,
  input  logic                 eng_busy,
  input  logic                 eng_done,
  input  logic [7:0]           eng_rx,
  output logic [3:0]           spi_cs_n
);
  localparam int IDXW    = (NREQ > 2) ? 2 : 1;
  localparam int CNTW    = 16;
  localparam int SETUP_C = (CS_SETUP < 1) ? 1 : CS_SETUP;
  localparam int HOLD_C  = (CS_HOLD < 1) ? 1 : CS_HOLD;
  localparam int GAP_C   = (CS_GAP < 1) ? 1 : CS_GAP;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_XFER  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // First asserted request at or after p, wrapping modulo NREQ.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDXW-1:0] p);
    logic [IDXW-1:0] w;
    w = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[(int'(p) + i) % NREQ]) begin
        w = IDXW'((int'(p) + i) % NREQ);
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic logic [NREQ-1:0] idx_onehot(input logic [IDXW-1:0] i);
    idx_onehot    = '0;
    idx_onehot[i] = 1'b1;
  endfunction

  function automatic logic [3:0] cs_mask(input logic [1:0] c);
    cs_mask    = 4'hF;
    cs_mask[c] = 1'b0;
  endfunction

  state_t            state_r, state_s;
  logic [CNTW-1:0]   cnt_r, cnt_s, cnt_lim_s;
  logic [LENW-1:0]   rem_r, rem_s, pick_len_s;
  logic [IDXW-1:0]   own_r, own_s, ptr_r, ptr_s, pick_s;
  logic [1:0]        csel_r, csel_s, pick_cs_s;
  logic [NREQ-1:0]   gnt_r, gnt_s, ready_r, ready_s, rx_valid_r, rx_valid_s, done_r, done_s;
  logic              start_r, start_s, cnt_end_s, load_go_s, last_byte_s;
  logic [7:0]        eng_tx_r, eng_tx_s, rx_data_r, rx_data_s;
  logic [3:0]        cs_n_r, cs_n_s;

  assign pick_s      = rr_pick(req, ptr_r);
  assign pick_len_s  = req_len[int'(pick_s)*LENW +: LENW];
  assign pick_cs_s   = req_cs[int'(pick_s)*2 +: 2];
  assign load_go_s   = req_tx_valid[own_r] & ~eng_busy;
  // An abort only takes effect at a byte boundary, so the byte in flight always finishes.
  assign last_byte_s = (rem_r == LENW'(1)) | ~req[own_r];
  assign cnt_end_s   = (cnt_r == cnt_lim_s);

  // Terminal count of the timed states
  always_comb begin
    cnt_lim_s = '0;
    case (state_r)
      ST_SETUP: cnt_lim_s = CNTW'(SETUP_C - 1);
      ST_HOLD:  cnt_lim_s = CNTW'(HOLD_C - 1);
      ST_GAP:   cnt_lim_s = CNTW'(GAP_C - 1);
      default:  cnt_lim_s = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (|req && pick_len_s != '0) state_s = ST_SETUP; else state_s = ST_IDLE;
      ST_SETUP: if (cnt_end_s) state_s = ST_LOAD; else state_s = ST_SETUP;
      ST_LOAD:  if (load_go_s) state_s = ST_XFER; else state_s = ST_LOAD;
      ST_XFER: begin
        if (eng_done) state_s = last_byte_s ? ST_HOLD : ST_LOAD;
        else          state_s = ST_XFER;
      end
      ST_HOLD:  if (cnt_end_s) state_s = ST_GAP; else state_s = ST_HOLD;
      ST_GAP:   if (cnt_end_s) state_s = ST_IDLE; else state_s = ST_GAP;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output
  always_comb begin
    cnt_s      = '0;
    rem_s      = rem_r;
    own_s      = own_r;
    csel_s     = csel_r;
    ptr_s      = ptr_r;
    gnt_s      = gnt_r;
    ready_s    = '0;
    rx_valid_s = '0;
    done_s     = '0;
    start_s    = 1'b0;
    eng_tx_s   = eng_tx_r;
    rx_data_s  = rx_data_r;
    cs_n_s     = cs_n_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          gnt_s  = idx_onehot(pick_s);
          own_s  = pick_s;
          csel_s = pick_cs_s;
          rem_s  = pick_len_s;
          ptr_s  = IDXW'((int'(pick_s) + 1) % NREQ);
          // A zero-length request is acknowledged without touching CS or the engine.
          if (pick_len_s != '0) cs_n_s = cs_mask(pick_cs_s);
          else                  done_s = idx_onehot(pick_s);
        end else begin
          gnt_s = '0;
        end
      end
      ST_SETUP, ST_GAP: begin
        if (!cnt_end_s) cnt_s = cnt_r + CNTW'(1);
        else            cnt_s = '0;
      end
      ST_LOAD: begin
        if (load_go_s) begin
          ready_s  = idx_onehot(own_r);
          start_s  = 1'b1;
          eng_tx_s = req_tx_data[int'(own_r)*8 +: 8];
        end else begin
          start_s = 1'b0;
        end
      end
      ST_XFER: begin
        if (eng_done) begin
          rx_valid_s = idx_onehot(own_r);
          rx_data_s  = eng_rx;
          rem_s      = rem_r - LENW'(1);
        end else begin
          rem_s = rem_r;
        end
      end
      ST_HOLD: begin
        if (!cnt_end_s) begin
          cnt_s = cnt_r + CNTW'(1);
        end else begin
          cs_n_s = 4'hF;
          gnt_s  = '0;
          done_s = idx_onehot(own_r);
        end
      end
      default: begin
        cs_n_s = 4'hF;
        gnt_s  = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      rem_r      <= '0;
      own_r      <= '0;
      csel_r     <= 2'd0;
      ptr_r      <= '0;
      gnt_r      <= '0;
      ready_r    <= '0;
      rx_valid_r <= '0;
      done_r     <= '0;
      start_r    <= 1'b0;
      eng_tx_r   <= 8'h00;
      rx_data_r  <= 8'h00;
      cs_n_r     <= 4'hF;
    end else begin
      cnt_r      <= cnt_s;
      rem_r      <= rem_s;
      own_r      <= own_s;
      csel_r     <= csel_s;
      ptr_r      <= ptr_s;
      gnt_r      <= gnt_s;
      ready_r    <= ready_s;
      rx_valid_r <= rx_valid_s;
      done_r     <= done_s;
      start_r    <= start_s;
      eng_tx_r   <= eng_tx_s;
      rx_data_r  <= rx_data_s;
      cs_n_r     <= cs_n_s;
    end
  end

  assign req_tx_ready = ready_r;
  assign gnt          = gnt_r;
  assign rx_data      = rx_data_r;
  assign rx_valid     = rx_valid_r;
  assign done         = done_r;
  assign eng_start    = start_r;
  assign eng_tx       = eng_tx_r;
  assign spi_cs_n     = cs_n_r;

endmodule

// File: tb/tb_qar_spi_arbiter.sv
// Bench for qar_spi_arbiter: loopback byte engine, table of single transactions,
// and hand-written sequences for round robin, abort, TX stall and reset.
module tb_qar_spi_arbiter;
  localparam int NREQ = 2, LENW = 8, CS_SETUP = 2, CS_HOLD = 2, CS_GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    req_cs;
  logic [LENW*NREQ-1:0] req_len;
  wire  [8*NREQ-1:0]    req_tx_data;
  logic [NREQ-1:0]      req_tx_valid, req_tx_ready, gnt, rx_valid, done;
  logic [7:0]           rx_data, eng_tx;
  logic                 eng_start;
  logic                 eng_busy = 1'b0;
  logic [7:0]           eng_rx = 8'h00;
  logic [3:0]           spi_cs_n;
  logic                 mdl_done = 1'b0, man_done;
  wire                  eng_done = mdl_done | man_done;

  qar_spi_arbiter #(.NREQ(NREQ), .LENW(LENW), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cs(req_cs), .req_len(req_len),
    .req_tx_data(req_tx_data), .req_tx_valid(req_tx_valid), .req_tx_ready(req_tx_ready),
    .gnt(gnt), .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
    .eng_start(eng_start), .eng_tx(eng_tx), .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_rx(eng_rx), .spi_cs_n(spi_cs_n)
  );

  typedef struct {
    int          who;
    logic [1:0]  cs;
    logic [7:0]  len;
    logic [31:0] dat;   // byte j in dat[8j+:8]
    logic [3:0]  csn;   // CS pattern while granted
  } vec_t;
  vec_t vt [5];

  int total = 0, bad = 0;
  int cyc = 0, start_cnt = 0, cs_low_cyc = 0, cs_multi = 0, cs_bad = 0;
  int last_rx_cyc = 0, done_cyc = 0, rx_n = 0, gnt_n = 0, gap_n = 0, gap_run = 0, eng_left = 0;
  int rx_cnt [NREQ] = '{default: 0};
  int done_cnt [NREQ] = '{default: 0};
  int gnt_cyc [NREQ] = '{default: 0};
  int tx_idx [NREQ] = '{default: 0};
  int tx_base [NREQ];
  logic [7:0] tx_bytes [NREQ][4];
  logic [7:0] rx_log [256];
  int gnt_log [64];
  int gap_log [64];
  logic [NREQ-1:0] gnt_prev = '0;
  logic [3:0] exp_csn;
  logic [7:0] eng_hold = 8'h00;

  for (genvar g = 0; g < NREQ; g++) begin : g_feed
    assign req_tx_data[8*g +: 8] = tx_bytes[g][2'(tx_idx[g] - tx_base[g])];
  end

  // Monitor plus loopback engine: eng_done 8 cycles after eng_start, eng_rx = eng_tx.
  always @(negedge clk) begin
    cyc++;
    if ($countones(~spi_cs_n) > 1) cs_multi++;
    if (spi_cs_n != 4'hF) cs_low_cyc++;
    if (gnt != '0 && spi_cs_n != exp_csn) cs_bad++;
    if (eng_start) start_cnt++;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_cyc[i]++;
      if (gnt[i] && !gnt_prev[i]) begin gnt_log[gnt_n % 64] = i; gnt_n++; end
      if (rx_valid[i]) begin rx_cnt[i]++; rx_log[rx_n % 256] = rx_data; rx_n++; last_rx_cyc = cyc; end
      if (done[i]) begin done_cnt[i]++; done_cyc = cyc; end
      if (req_tx_ready[i]) tx_idx[i]++;
    end
    gnt_prev = gnt;
    if (spi_cs_n == 4'hF) gap_run++;
    else begin
      if (gap_run > 0) begin gap_log[gap_n % 64] = gap_run; gap_n++; end
      gap_run = 0;
    end
    mdl_done = 1'b0;
    if (rst) begin
      eng_left = 0; eng_busy = 1'b0;
    end else if (eng_left != 0) begin
      eng_left--;
      if (eng_left == 0) begin mdl_done = 1'b1; eng_busy = 1'b0; eng_rx = eng_hold; end
    end
    if (!rst && eng_start) begin eng_left = 8; eng_busy = 1'b1; eng_hold = eng_tx; end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int who, input string name);
    bit seen = 1'b0;
    for (int w = 0; w < 300 && !seen; w++) begin
      step();
      if (done[who]) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int s_rx, s_dn, s_st, s_bad, s_low, s_gc, s_rn;
    v = vt[k];
    s_rx = rx_cnt[v.who]; s_dn = done_cnt[v.who]; s_st = start_cnt; s_bad = cs_bad;
    s_low = cs_low_cyc; s_gc = gnt_cyc[v.who]; s_rn = rx_n;
    exp_csn = v.csn;
    for (int j = 0; j < 4; j++) tx_bytes[v.who][j] = v.dat[8*j +: 8];
    tx_base[v.who] = tx_idx[v.who];
    req_cs[2*v.who +: 2] = v.cs;
    req_len[LENW*v.who +: LENW] = v.len;
    req_tx_valid[v.who] = 1'b1;
    req[v.who] = 1'b1;
    wait_done(v.who, $sformatf("v%0d_done_seen", k));
    req[v.who] = 1'b0;
    req_tx_valid[v.who] = 1'b0;
    repeat (CS_GAP + 4) step();
    chk($sformatf("v%0d_rx_count", k), rx_cnt[v.who] - s_rx, int'(v.len));
    chk($sformatf("v%0d_done_count", k), done_cnt[v.who] - s_dn, 1);
    chk($sformatf("v%0d_start_count", k), start_cnt - s_st, int'(v.len));
    chk($sformatf("v%0d_cs_pattern", k), cs_bad - s_bad, 0);
    for (int j = 0; j < int'(v.len); j++)
      chk($sformatf("v%0d_rx_byte%0d", k, j), int'(rx_log[(s_rn + j) % 256]), int'(v.dat[8*j +: 8]));
    if (v.len != 8'd0) begin
      chk($sformatf("v%0d_hold_time", k), done_cyc - last_rx_cyc, CS_HOLD);
    end else begin
      chk($sformatf("v%0d_gnt_cycles", k), gnt_cyc[v.who] - s_gc, 1);
      chk($sformatf("v%0d_cs_untouched", k), cs_low_cyc - s_low, 0);
    end
  endtask

  initial begin
    int s_rx, s_dn, s_st, s_gn, s_gp, n, gmin;
    rst = 1'b1; req = '0; req_cs = '0; req_len = '0; req_tx_valid = '0; man_done = 1'b0;
    exp_csn = 4'hF;
    for (int i = 0; i < NREQ; i++) begin
      tx_base[i] = 0;
      for (int j = 0; j < 4; j++) tx_bytes[i][j] = 8'h00;
    end
    vt[0] = '{0, 2'd2, 8'd2, 32'h0000_3CA5, 4'b1011};
    vt[1] = '{1, 2'd0, 8'd1, 32'h0000_005A, 4'b1110};
    vt[2] = '{1, 2'd3, 8'd0, 32'h0000_0000, 4'b1111};
    vt[3] = '{0, 2'd1, 8'd3, 32'h0033_2211, 4'b1101};
    vt[4] = '{1, 2'd3, 8'd2, 32'h0000_7EC3, 4'b0111};

    repeat (3) step();
    chk("rst_cs_n", int'(spi_cs_n), 32'hF);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_pulses", int'({req_tx_ready, rx_valid, done, eng_start}), 0);
    chk("rst_data", int'({eng_tx, rx_data}), 0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 5; k++) run_vec(k);

    // Round robin between two persistent requesters
    rst = 1'b1; step(); step(); rst = 1'b0;
    s_gn = gnt_n; s_gp = gap_n;
    req_cs = {2'd1, 2'd0}; req_len = {8'd1, 8'd1}; req_tx_valid = 2'b11; req = 2'b11;
    n = 0;
    for (int w = 0; w < 600 && n < 4; w++) begin
      step();
      if (|done) n++;
    end
    req = '0; req_tx_valid = '0;
    repeat (CS_GAP + 4) step();
    chk("rr_done_count", n, 4);
    for (int j = 0; j < 4; j++) chk($sformatf("rr_order%0d", j), gnt_log[(s_gn + j) % 64], j % 2);
    chk("rr_gap_count", gap_n - s_gp, 4);
    gmin = 1000;
    for (int j = s_gp; j < gap_n; j++) if (gap_log[j % 64] < gmin) gmin = gap_log[j % 64];
    chk("rr_gap_min_ok", int'(gmin >= CS_GAP), 1);

    // Abort during byte 2 of a 4-byte transaction
    s_rx = rx_cnt[0]; s_dn = done_cnt[0]; s_st = start_cnt; n = rx_n;
    exp_csn = 4'b1110;
    for (int j = 0; j < 4; j++) tx_bytes[0][j] = 8'(j + 1);
    tx_base[0] = tx_idx[0];
    req_cs[1:0] = 2'd0; req_len[7:0] = 8'd4; req_tx_valid[0] = 1'b1; req[0] = 1'b1;
    s_gn = 0;
    for (int w = 0; w < 300 && s_gn < 2; w++) begin
      step();
      if (eng_start) s_gn++;
    end
    repeat (3) step();
    req[0] = 1'b0;
    wait_done(0, "abort_done_seen");
    req_tx_valid[0] = 1'b0;
    repeat (CS_GAP + 4) step();
    chk("abort_rx_count", rx_cnt[0] - s_rx, 2);
    chk("abort_done_count", done_cnt[0] - s_dn, 1);
    chk("abort_start_count", start_cnt - s_st, 2);
    chk("abort_rx_byte1", int'(rx_log[(n + 1) % 256]), 32'h02);
    chk("abort_cs_high", int'(spi_cs_n), 32'hF);

    // TX byte withheld in LOAD
    s_st = start_cnt; n = rx_n;
    exp_csn = 4'b0111;
    tx_bytes[0][0] = 8'h9C; tx_base[0] = tx_idx[0];
    req_cs[1:0] = 2'd3; req_len[7:0] = 8'd1; req_tx_valid[0] = 1'b0; req[0] = 1'b1;
    repeat (1 + CS_SETUP + 1 + 10) step();
    chk("stall_cs_low", int'(spi_cs_n), 32'h7);
    chk("stall_no_start", start_cnt - s_st, 0);
    req_tx_valid[0] = 1'b1;
    step();
    chk("stall_start_edge", int'(eng_start), 1);
    chk("stall_tx_ready", int'(req_tx_ready), 1);
    wait_done(0, "stall_done_seen");
    req[0] = 1'b0; req_tx_valid[0] = 1'b0;
    repeat (CS_GAP + 4) step();
    chk("stall_rx_byte", int'(rx_log[n % 256]), 32'h9C);

    // Reset in XFER, then a stale eng_done
    exp_csn = 4'b1101;
    req_cs[1:0] = 2'd1; req_len[7:0] = 8'd2; req_tx_valid[0] = 1'b1; req[0] = 1'b1;
    s_gn = 0;
    for (int w = 0; w < 300 && s_gn < 1; w++) begin
      step();
      if (eng_start) s_gn++;
    end
    repeat (2) step();
    s_rx = rx_cnt[0]; s_dn = done_cnt[0];
    rst = 1'b1; req[0] = 1'b0; req_tx_valid[0] = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_xfer_cs_n", int'(spi_cs_n), 32'hF);
    chk("rst_xfer_gnt", int'(gnt), 0);
    chk("rst_xfer_data", int'({eng_tx, rx_data}), 0);
    s_st = start_cnt;
    step(); step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    repeat (12) step();
    chk("rst_xfer_no_rx", rx_cnt[0] - s_rx, 0);
    chk("rst_xfer_no_done", done_cnt[0] - s_dn, 0);
    chk("rst_xfer_no_start", start_cnt - s_st, 0);
    run_vec(0);

    chk("never_two_cs_low", cs_multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
